// File: rtl/alu_issue_stage.sv
// Issue stage for a 32-bit combinational ALU: it registers one request, runs one EXEC
// cycle against the external ALU, then holds the result in DONE until it is taken.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_operation,
    output logic        alu_binvert,
    output logic        alu_carryin,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_illegal,
    output logic        ovf_sticky,
    input  logic        ovf_clear
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_ILL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_live;
    logic   w_accept;
    logic   w_legal;
    logic   w_ovf_kept;

    // r_live holds in_ready low until the first edge after reset release.
    always_comb begin
        in_ready = r_live && ((r_state == ST_IDLE) ||
                              ((r_state == ST_DONE) && out_ready));
        w_accept   = in_valid && in_ready;
        w_legal    = (in_op != OP_ILL);
        w_ovf_kept = alu_overflow &&
                     ((alu_operation == OP_ADD) || (alu_operation == OP_SUB));
        out_valid  = (r_state == ST_DONE);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_legal ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nxt = w_legal ? ST_EXEC : ST_DONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // Operands and ALU control only move on a legal acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            alu_binvert   <= 1'b0;
            alu_carryin   <= 1'b0;
        end else if (w_accept && w_legal) begin
            alu_a         <= in_a;
            alu_b         <= in_b;
            alu_operation <= in_op;
            alu_binvert   <= (in_op == OP_SUB) || (in_op == OP_SLT);
            alu_carryin   <= (in_op == OP_SUB) || (in_op == OP_SLT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            out_result   <= alu_result;
            out_zero     <= (alu_result == '0);
            out_overflow <= w_ovf_kept;
            out_illegal  <= 1'b0;
        end else if (w_accept && !w_legal) begin
            out_result   <= '0;
            out_zero     <= 1'b1;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b1;
        end
    end

    // A capture that sets the sticky bit wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if ((r_state == ST_EXEC) && w_ovf_kept) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 32-bit ALU wired to its ALU port.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_operation;
    logic        alu_binvert;
    logic        alu_carryin;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_illegal;
    logic        ovf_sticky;
    logic        ovf_clear;
    logic        force_ovf;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_op         (in_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_binvert   (alu_binvert),
        .alu_carryin   (alu_carryin),
        .alu_result    (alu_result),
        .alu_overflow  (alu_overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_illegal   (out_illegal),
        .ovf_sticky    (ovf_sticky),
        .ovf_clear     (ovf_clear)
    );

    always #5 clk = ~clk;

    // External ALU; force_ovf lets a step drive alu_overflow high regardless of op.
    logic [31:0] w_sum;
    logic [31:0] w_dif;
    always_comb begin
        w_sum        = alu_a + alu_b;
        w_dif        = alu_a - alu_b;
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_operation)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = w_sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = w_dif;
                alu_overflow = (alu_a[31] != alu_b[31]) && (w_dif[31] != alu_a[31]);
            end
            3'b011: alu_result = ~(alu_a & alu_b);
            3'b100: alu_result = ~(alu_a | alu_b);
            3'b111: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
        if (force_ovf) alu_overflow = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 3'b000;
        out_ready = 1'b1;
        ovf_clear = 1'b0;
        force_ovf = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_a",     alu_a, 32'd0);
        chk("rst_alu_op",    32'(alu_operation), 32'd0);
        chk("rst_sticky",    32'(ovf_sticky), 32'd0);
        in_valid = 1'b1;
        in_op    = 3'b010;
        tick();
        tick();
        chk("rst_no_accept", 32'(alu_operation), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rel_ready_high", 32'(in_ready), 32'd1);

        // ADD 0x7FFFFFFF + 1 overflows
        in_valid = 1'b1; in_op = 3'b010; in_a = 32'h7FFF_FFFF; in_b = 32'd1;
        tick();
        in_valid = 1'b0;
        chk("add_exec_ready", 32'(in_ready), 32'd0);
        chk("add_exec_valid", 32'(out_valid), 32'd0);
        chk("add_alu_a",      alu_a, 32'h7FFF_FFFF);
        chk("add_binvert",    32'(alu_binvert), 32'd0);
        tick();
        chk("add_valid",   32'(out_valid), 32'd1);
        chk("add_result",  out_result, 32'h8000_0000);
        chk("add_ovf",     32'(out_overflow), 32'd1);
        chk("add_sticky",  32'(ovf_sticky), 32'd1);
        chk("add_zero",    32'(out_zero), 32'd0);
        chk("add_illegal", 32'(out_illegal), 32'd0);
        tick();
        chk("add_to_idle", 32'(out_valid), 32'd0);

        // SUB 5 - 5
        in_valid = 1'b1; in_op = 3'b110; in_a = 32'd5; in_b = 32'd5;
        tick();
        in_valid = 1'b0;
        chk("sub_binvert", 32'(alu_binvert), 32'd1);
        chk("sub_carryin", 32'(alu_carryin), 32'd1);
        chk("sub_aluop",   32'(alu_operation), 32'd6);
        tick();
        chk("sub_result", out_result, 32'd0);
        chk("sub_zero",   32'(out_zero), 32'd1);
        chk("sub_ovf",    32'(out_overflow), 32'd0);
        chk("sub_sticky_kept", 32'(ovf_sticky), 32'd1);
        tick();

        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);

        // SLT -1 < 1 with alu_overflow forced high
        force_ovf = 1'b1;
        in_valid = 1'b1; in_op = 3'b111; in_a = 32'hFFFF_FFFF; in_b = 32'd1;
        tick();
        in_valid = 1'b0;
        chk("slt_binvert", 32'(alu_binvert), 32'd1);
        chk("slt_carryin", 32'(alu_carryin), 32'd1);
        tick();
        chk("slt_result", out_result, 32'd1);
        chk("slt_ovf",    32'(out_overflow), 32'd0);
        chk("slt_sticky", 32'(ovf_sticky), 32'd0);
        force_ovf = 1'b0;
        tick();

        // Illegal op: one-edge latency, ALU control untouched
        in_valid = 1'b1; in_op = 3'b101; in_a = 32'h1234_5678; in_b = 32'd9;
        tick();
        in_valid = 1'b0;
        chk("ill_valid",   32'(out_valid), 32'd1);
        chk("ill_illegal", 32'(out_illegal), 32'd1);
        chk("ill_result",  out_result, 32'd0);
        chk("ill_zero",    32'(out_zero), 32'd1);
        chk("ill_aluop",   32'(alu_operation), 32'd7);
        chk("ill_alu_a",   alu_a, 32'hFFFF_FFFF);
        chk("ill_binvert", 32'(alu_binvert), 32'd1);
        tick();

        // Backpressure with a pending request
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b001; in_a = 32'h0000_00F0; in_b = 32'h0000_000F;
        tick();
        in_op = 3'b000; in_a = 32'h0000_AAAA; in_b = 32'h0000_5555;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(out_valid), 32'd1);
            chk("bp_result", out_result, 32'h0000_00FF);
            chk("bp_ready",  32'(in_ready), 32'd0);
            chk("bp_alu_a",  alu_a, 32'h0000_00F0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_up", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_alu_a", alu_a, 32'h0000_AAAA);
        chk("bp_next_op",    32'(alu_operation), 32'd0);
        chk("bp_next_valid", 32'(out_valid), 32'd0);
        tick();
        chk("and_result", out_result, 32'd0);
        chk("and_zero",   32'(out_zero), 32'd1);
        tick();

        // Sticky set and clear on the same edge; then illegal accepted from DONE
        in_valid = 1'b1; in_op = 3'b010; in_a = 32'h7FFF_FFFF; in_b = 32'h7FFF_FFFF;
        tick();
        in_valid = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("setclr_sticky", 32'(ovf_sticky), 32'd1);
        chk("setclr_result", out_result, 32'hFFFF_FFFE);
        chk("setclr_ovf",    32'(out_overflow), 32'd1);
        chk("done_ready",    32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = 3'b101;
        tick();
        in_valid = 1'b0;
        chk("done_ill_valid",   32'(out_valid), 32'd1);
        chk("done_ill_illegal", 32'(out_illegal), 32'd1);
        tick();

        // Reset mid-EXEC
        in_valid = 1'b1; in_op = 3'b010; in_a = 32'd3; in_b = 32'd4;
        tick();
        in_valid = 1'b0;
        chk("mid_alu_a", alu_a, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ready",   32'(in_ready), 32'd0);
        chk("mid_valid",   32'(out_valid), 32'd0);
        chk("mid_alu_a0",  alu_a, 32'd0);
        chk("mid_alu_b0",  alu_b, 32'd0);
        chk("mid_aluop0",  32'(alu_operation), 32'd0);
        chk("mid_sticky0", 32'(ovf_sticky), 32'd0);
        chk("mid_illegal0", 32'(out_illegal), 32'd0);
        chk("mid_zero0",   32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("post_valid", 32'(out_valid), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
